// File: rtl/window_seq.sv
// Raster-scan sequencer for a 3x3 sobel window: issues image ROM reads under
// downstream back-pressure and tracks row/col of each returned pixel.
module window_seq #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 96,
    parameter int ADDR_W = 14,
    localparam int CW    = $clog2(IMG_W),
    localparam int RW    = $clog2(IMG_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              ready,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              pix_we,
    output logic [RW-1:0]     pix_row,
    output logic [CW-1:0]     pix_col,
    output logic              win_valid,
    output logic              busy,
    output logic              frame_done,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [RW-1:0]       row_q, row_d;
    logic [CW-1:0]       col_q, col_d;
    logic                pix_we_q, pix_we_d;
    logic [RW-1:0]       pix_row_q, pix_row_d;
    logic [CW-1:0]       pix_col_q, pix_col_d;
    logic                rd_issue;
    logic                last_rd;

    // Handshake: a read is issued on every RUN cycle where ready=1 and no abort;
    // its pixel appears one cycle later on pix_we whatever ready does then.
    assign rd_issue = (state_q == S_RUN) && ready && !abort;
    assign last_rd  = rd_issue && (row_q == ROW_LAST) && (col_q == COL_LAST);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        row_d     = row_q;
        col_d     = col_q;
        pix_we_d  = rd_issue;
        pix_row_d = pix_row_q;
        pix_col_d = pix_col_q;

        if (rd_issue) begin
            pix_row_d = row_q;
            pix_col_d = col_q;
            addr_d    = addr_q + ADDR_W'(1);
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    addr_d  = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_RUN:   if (last_rd) state_d = S_FLUSH;
            S_FLUSH: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort beats start and kills any pixel that would land next cycle.
        if (abort) begin
            state_d  = S_IDLE;
            pix_we_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            pix_we_q  <= 1'b0;
            pix_row_q <= '0;
            pix_col_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            row_q     <= row_d;
            col_q     <= col_d;
            pix_we_q  <= pix_we_d;
            pix_row_q <= pix_row_d;
            pix_col_q <= pix_col_d;
        end
    end

    assign rom_en     = rd_issue;
    assign rom_addr   = addr_q;
    assign pix_we     = pix_we_q;
    assign pix_row    = pix_row_q;
    assign pix_col    = pix_col_q;
    assign win_valid  = pix_we_q && (pix_row_q >= RW'(2)) && (pix_col_q >= CW'(2));
    assign busy       = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign frame_done = (state_q == S_DONE);
    assign dbg_state  = state_q;

endmodule
